// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCK/CS_N/MOSI on clk, deserialises MOSI bytes, serialises MISO bytes.
// Build option SPI_TARGET_ECHO_EN: on tx underrun the last received byte is echoed instead of IDLE_FILL.
module spi_target #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Each synchroniser stage carries {sck, cs_n, mosi}; cs_n idles high out of reset.
  localparam logic [2:0] SYNC_IDLE = 3'b010;

  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic                        sck_prev_reg;
  logic                        cs_prev_reg;

  state_t      state_reg, state_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic        reload_pending_reg, reload_pending_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        miso_reg, miso_next;
  logic [7:0]  hold_reg, hold_next;
  logic        full_reg, full_next;

  logic        sck_s, cs_s, mosi_s;
  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic        accept;
  logic        reload;
  logic [7:0]  fill_byte;
  logic [7:0]  reload_byte;

  assign sck_s  = sync_reg[SYNC_STAGES-1][2];
  assign cs_s   = sync_reg[SYNC_STAGES-1][1];
  assign mosi_s = sync_reg[SYNC_STAGES-1][0];

  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign cs_rise  = cs_s & ~cs_prev_reg;
  assign cs_fall  = ~cs_s & cs_prev_reg;

  assign accept = tx_valid & ~full_reg;

`ifdef SPI_TARGET_ECHO_EN
  assign fill_byte = rx_data_reg;
`else
  assign fill_byte = IDLE_FILL;
`endif

  assign reload_byte = full_reg ? hold_reg : fill_byte;

  always_comb begin
    state_next          = state_reg;
    rx_shift_next       = rx_shift_reg;
    tx_shift_next       = tx_shift_reg;
    bit_cnt_next        = bit_cnt_reg;
    reload_pending_next = reload_pending_reg;
    rx_data_next        = rx_data_reg;
    rx_valid_next       = 1'b0;
    miso_next           = miso_reg;
    reload              = 1'b0;

    if (cs_rise) begin
      // Deselect aborts the frame; the holding register is deliberately left alone.
      state_next          = IDLE;
      miso_next           = 1'b0;
      bit_cnt_next        = 3'd0;
      rx_shift_next       = 8'h00;
      reload_pending_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_next = LOAD;
          end
        end
        LOAD: begin
          reload       = 1'b1;
          bit_cnt_next = 3'd0;
          state_next   = ACTIVE;
        end
        ACTIVE: begin
          if (sck_rise) begin
            rx_shift_next = {rx_shift_reg[6:0], mosi_s};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next        = {rx_shift_reg[6:0], mosi_s};
              rx_valid_next       = 1'b1;
              reload_pending_next = 1'b1;
            end
          end else if (sck_fall) begin
            // The fall after a byte boundary presents the next byte's MSB instead of shifting.
            if (reload_pending_reg) begin
              reload              = 1'b1;
              reload_pending_next = 1'b0;
            end else begin
              tx_shift_next = {tx_shift_reg[6:0], 1'b0};
              miso_next     = tx_shift_reg[6];
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (reload) begin
      tx_shift_next = reload_byte;
      miso_next     = reload_byte[7];
    end
  end

  // Accept only happens when empty, so a reload never competes with a new byte for the register.
  always_comb begin
    hold_next = hold_reg;
    full_next = full_reg;
    if (reload && full_reg) begin
      full_next = 1'b0;
    end
    if (accept) begin
      hold_next = tx_data;
      full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg           <= {SYNC_STAGES{SYNC_IDLE}};
      sck_prev_reg       <= 1'b0;
      cs_prev_reg        <= 1'b1;
      state_reg          <= IDLE;
      rx_shift_reg       <= 8'h00;
      tx_shift_reg       <= 8'h00;
      bit_cnt_reg        <= 3'd0;
      reload_pending_reg <= 1'b0;
      rx_data_reg        <= 8'h00;
      rx_valid_reg       <= 1'b0;
      miso_reg           <= 1'b0;
      hold_reg           <= 8'h00;
      full_reg           <= 1'b0;
    end else begin
      sync_reg           <= {sync_reg[SYNC_STAGES-2:0], sck, cs_n, mosi};
      sck_prev_reg       <= sck_s;
      cs_prev_reg        <= cs_s;
      state_reg          <= state_next;
      rx_shift_reg       <= rx_shift_next;
      tx_shift_reg       <= tx_shift_next;
      bit_cnt_reg        <= bit_cnt_next;
      reload_pending_reg <= reload_pending_next;
      rx_data_reg        <= rx_data_next;
      rx_valid_reg       <= rx_valid_next;
      miso_reg           <= miso_next;
      hold_reg           <= hold_next;
      full_reg           <= full_next;
    end
  end

  assign miso     = miso_reg;
  assign miso_oe  = (state_reg != IDLE);
  assign busy     = (state_reg != IDLE);
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_ready = ~full_reg;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table-driven single-byte frames plus hand-written corner sequences.
module tb_spi_target;

`ifdef SPI_TARGET_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx_q [$];
  logic [7:0] exp_miso_q [$];
  logic [7:0] mosi_buf [3];

  typedef struct {
    logic [7:0] mosi_byte;
    logic       offer;
    logic [7:0] tx_byte;
    logic [7:0] exp_plain;
    logic [7:0] exp_echo;
  } vec_t;

  vec_t vecs [5];

  spi_target #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end else begin
      $display("[TB] ok %s = %02h", name, got);
    end
  endtask

  // Scoreboard: every rx_valid strobe must match the oldest byte the master sent.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (exp_rx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got %02h expected no strobe", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
  end

  task automatic offer_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame of nbits; full bytes compare MISO against exp_miso_q, then checks deselect timing.
  task automatic spi_frame(input int nbits);
    logic [7:0] got [3];
    int b;
    int k;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_selected", {7'd0, busy}, 8'd1);
    for (int i = 0; i < nbits; i++) begin
      b = i / 8;
      k = 7 - (i % 8);
      mosi = mosi_buf[b][k];
      repeat (HALF) @(negedge clk);
      got[b][k] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      if (k == 0) begin
        check("miso_byte", got[b], exp_miso_q.pop_front());
      end
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("miso_oe_before_deselect", {7'd0, miso_oe}, 8'd1);
    @(negedge clk);
    check("miso_oe_after_deselect", {7'd0, miso_oe}, 8'd0);
    check("busy_after_deselect", {7'd0, busy}, 8'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h81, 1'b0, 8'h00, 8'hFF, 8'h3C};
    vecs[2] = '{8'h00, 1'b1, 8'h5A, 8'h5A, 8'h5A};
    vecs[3] = '{8'h7E, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{8'hE6, 1'b0, 8'h00, 8'hFF, 8'h7E};

    // Reset held with the bus active.
    cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sck = ~sck;
    end
    check("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_miso", {7'd0, miso}, 8'd0);
    sck = 1'b0;
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single-byte frames from the table.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].offer) begin
        offer_tx(vecs[v].tx_byte);
        check("tx_ready_after_load", {7'd0, tx_ready}, 8'd0);
      end
      mosi_buf[0] = vecs[v].mosi_byte;
      exp_rx_q.push_back(vecs[v].mosi_byte);
      exp_miso_q.push_back(ECHO ? vecs[v].exp_echo : vecs[v].exp_plain);
      spi_frame(8);
      check("tx_ready_after_frame", {7'd0, tx_ready}, 8'd1);
    end

    // Three-byte frame with only one queued tx byte.
    offer_tx(8'h11);
    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02; mosi_buf[2] = 8'h03;
    exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h02); exp_rx_q.push_back(8'h03);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(ECHO ? 8'h01 : 8'hFF);
    exp_miso_q.push_back(ECHO ? 8'h02 : 8'hFF);
    spi_frame(24);

    // Deselect after five bits: no strobe, then a clean frame.
    mosi_buf[0] = 8'hF0;
    spi_frame(5);
    mosi_buf[0] = 8'h5A;
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(ECHO ? 8'h03 : 8'hFF);
    spi_frame(8);

    // Offer while full is dropped.
    offer_tx(8'h77);
    check("tx_ready_full", {7'd0, tx_ready}, 8'd0);
    offer_tx(8'hC3);
    check("tx_ready_still_full", {7'd0, tx_ready}, 8'd0);
    mosi_buf[0] = 8'h24;
    exp_rx_q.push_back(8'h24);
    exp_miso_q.push_back(8'h77);
    spi_frame(8);
    mosi_buf[0] = 8'h99;
    exp_rx_q.push_back(8'h99);
    exp_miso_q.push_back(ECHO ? 8'h24 : 8'hFF);
    spi_frame(8);

    // One-cycle reset in the middle of a byte, with a byte held.
    offer_tx(8'h42);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_miso_oe", {7'd0, miso_oe}, 8'd0);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_tx_ready", {7'd0, tx_ready}, 8'd1);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_miso", {7'd0, miso}, 8'd0);
    rst_n = 1'b1;
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    mosi_buf[0] = 8'h96;
    exp_rx_q.push_back(8'h96);
    exp_miso_q.push_back(ECHO ? 8'h00 : 8'hFF);
    spi_frame(8);

    check("rx_queue_drained", exp_rx_q.size()[7:0], 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
